// File: rtl/path_result_streamer.sv
// Streams the P (path result) SRAM out over a valid/ready port after the engine finishes,
// one word per READ/CAP/OUT pass, while accumulating a 16-bit checksum of accepted words.
module path_result_streamer #(
    parameter int A_WIDTH = 13,
    parameter int D_WIDTH = 8,
    parameter int N_WORDS = 2**A_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Go,
    input  logic [D_WIDTH-1:0] P_In,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic               P_En,
    output logic               P_Rw,
    output logic [D_WIDTH-1:0] Out_Data,
    output logic [A_WIDTH-1:0] Out_Addr,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [15:0]        Checksum,
    output logic               Busy,
    output logic               Done
);

    typedef enum logic [2:0] {IDLE, READ, CAP, OUT, DONE} state_t;

    // Termination is by compare so a full 2**A_WIDTH scan never relies on wrap.
    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(N_WORDS - 1);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic [A_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [D_WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]        csum_q, csum_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            csum_q     <= csum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        csum_d     = csum_q;
        case (state_q)
            IDLE: begin
                if (Go) begin
                    state_d = READ;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            READ: state_d = CAP;
            CAP: begin
                // SRAM data is valid the cycle after the address was presented.
                out_data_d = P_In;
                out_addr_d = cnt_q;
                state_d    = OUT;
            end
            OUT: begin
                if (Out_Ready) begin
                    csum_d = csum_q + 16'(out_data_q);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign P_Addr    = cnt_q;
    assign P_En      = (state_q == READ);
    assign P_Rw      = 1'b0;
    assign Out_Data  = out_data_q;
    assign Out_Addr  = out_addr_q;
    assign Out_Valid = (state_q == OUT);
    assign Checksum  = csum_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_path_result_streamer.sv
// Bench for path_result_streamer: three instances (N_WORDS 8, 4 and default) with SRAM models
// and per-instance scoreboards checked as words are accepted.
module tb_path_result_streamer;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Rst, Out_Ready;
    int   n_checks = 0, n_pass = 0;

    // instance a: N_WORDS=8, instance b: N_WORDS=4, instance c: default
    logic        go_a, go_b, go_c;
    logic [7:0]  pin_a, pin_b, pin_c;
    logic [12:0] paddr_a, paddr_b, paddr_c;
    logic        pen_a, pen_b, pen_c, prw_a, prw_b, prw_c;
    logic [7:0]  od_a, od_b, od_c;
    logic [12:0] oa_a, oa_b, oa_c;
    logic        ov_a, ov_b, ov_c;
    logic [15:0] ck_a, ck_b, ck_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

    path_result_streamer #(.A_WIDTH(13), .D_WIDTH(8), .N_WORDS(8)) dut_a (
        .Clk(Clk), .Rst(Rst), .Go(go_a), .P_In(pin_a), .P_Addr(paddr_a), .P_En(pen_a),
        .P_Rw(prw_a), .Out_Data(od_a), .Out_Addr(oa_a), .Out_Valid(ov_a),
        .Out_Ready(Out_Ready), .Checksum(ck_a), .Busy(busy_a), .Done(done_a));

    path_result_streamer #(.A_WIDTH(13), .D_WIDTH(8), .N_WORDS(4)) dut_b (
        .Clk(Clk), .Rst(Rst), .Go(go_b), .P_In(pin_b), .P_Addr(paddr_b), .P_En(pen_b),
        .P_Rw(prw_b), .Out_Data(od_b), .Out_Addr(oa_b), .Out_Valid(ov_b),
        .Out_Ready(Out_Ready), .Checksum(ck_b), .Busy(busy_b), .Done(done_b));

    path_result_streamer dut_c (
        .Clk(Clk), .Rst(Rst), .Go(go_c), .P_In(pin_c), .P_Addr(paddr_c), .P_En(pen_c),
        .P_Rw(prw_c), .Out_Data(od_c), .Out_Addr(oa_c), .Out_Valid(ov_c),
        .Out_Ready(Out_Ready), .Checksum(ck_c), .Busy(busy_c), .Done(done_c));

    // SRAM models: read data registered one cycle after an enabled address
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [4];
    always @(posedge Clk) begin
        if (pen_a && !prw_a) pin_a <= mem_a[paddr_a[2:0]];
        if (pen_b && !prw_b) pin_b <= mem_b[paddr_b[1:0]];
        if (pen_c && !prw_c) pin_c <= 8'hFF;
    end

    exp_t q_a[$], q_b[$], q_c[$];
    int   acc_a, acc_b, acc_c, dn_a, dn_b, dn_c, pe_b;

    // scoreboard monitors, sampled on the falling edge
    always @(negedge Clk) begin
        exp_t e;
        if (ov_a && Out_Ready) begin
            acc_a++; n_checks++;
            if (q_a.size() == 0) $display("FAIL sb_a: unexpected word addr=%0d data=%h", oa_a, od_a);
            else begin
                e = q_a.pop_front();
                if (oa_a !== e.addr || od_a !== e.data)
                    $display("FAIL sb_a: got addr=%0d data=%h want addr=%0d data=%h", oa_a, od_a, e.addr, e.data);
                else n_pass++;
            end
        end
        if (ov_b && Out_Ready) begin
            acc_b++; n_checks++;
            if (q_b.size() == 0) $display("FAIL sb_b: unexpected word addr=%0d data=%h", oa_b, od_b);
            else begin
                e = q_b.pop_front();
                if (oa_b !== e.addr || od_b !== e.data)
                    $display("FAIL sb_b: got addr=%0d data=%h want addr=%0d data=%h", oa_b, od_b, e.addr, e.data);
                else n_pass++;
            end
        end
        if (ov_c && Out_Ready) begin
            acc_c++; n_checks++;
            if (q_c.size() == 0) $display("FAIL sb_c: unexpected word addr=%0d data=%h", oa_c, od_c);
            else begin
                e = q_c.pop_front();
                if (oa_c !== e.addr || od_c !== e.data)
                    $display("FAIL sb_c: got addr=%0d data=%h want addr=%0d data=%h", oa_c, od_c, e.addr, e.data);
                else n_pass++;
            end
        end
        if (done_a) dn_a++;
        if (done_b) dn_b++;
        if (done_c) dn_c++;
        if (pen_b)  pe_b++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_a8();
        for (int i = 0; i < 8; i++) q_a.push_back('{addr: 13'(i), data: 8'(i)});
    endtask

    task automatic wait_done_a(input string name);
        for (int i = 0; i < 200 && !done_a; i++) tick(1);
        n_checks++;
        if (done_a !== 1'b1) $display("FAIL %s_timeout: Done=%b want 1", name, done_a); else n_pass++;
    endtask

    task automatic test_reset();
        Rst = 1'b1; go_a = 0; go_b = 0; go_c = 0; Out_Ready = 1'b0;
        tick(2);
        @(negedge Clk);
        n_checks++; if (paddr_a !== 13'd0) $display("FAIL rst_paddr: got %h want 0", paddr_a); else n_pass++;
        n_checks++; if (pen_a !== 1'b0) $display("FAIL rst_pen: got %b want 0", pen_a); else n_pass++;
        n_checks++; if (prw_a !== 1'b0) $display("FAIL rst_prw: got %b want 0", prw_a); else n_pass++;
        n_checks++; if (od_a !== 8'd0 || oa_a !== 13'd0) $display("FAIL rst_out: got %h/%h want 0/0", od_a, oa_a); else n_pass++;
        n_checks++; if (ov_a !== 1'b0) $display("FAIL rst_valid: got %b want 0", ov_a); else n_pass++;
        n_checks++; if (ck_a !== 16'd0) $display("FAIL rst_csum: got %h want 0", ck_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_busy_done: got %b%b want 00", busy_a, done_a); else n_pass++;
        Rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int edges;
        acc_a = 0; dn_a = 0; Out_Ready = 1'b1;
        push_a8();
        go_a = 1'b1; tick(1); go_a = 1'b0; edges = 1;
        while (!ov_a && edges < 10) begin tick(1); edges++; end
        n_checks++; if (edges !== 3) $display("FAIL basic_latency: got %0d edges want 3", edges); else n_pass++;
        wait_done_a("basic");
        n_checks++; if (ck_a !== 16'h001C) $display("FAIL basic_csum: got %h want 001c", ck_a); else n_pass++;
        tick(1);
        n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL basic_end: busy/done got %b%b want 00", busy_a, done_a); else n_pass++;
        n_checks++; if (dn_a !== 1 || acc_a !== 8 || q_a.size() !== 0)
            $display("FAIL basic_counts: done=%0d acc=%0d left=%0d want 1/8/0", dn_a, acc_a, q_a.size()); else n_pass++;
    endtask

    task automatic test_full_scan();
        acc_c = 0; dn_c = 0; Out_Ready = 1'b1;
        for (int i = 0; i < 8192; i++) q_c.push_back('{addr: 13'(i), data: 8'hFF});
        go_c = 1'b1; tick(1); go_c = 1'b0;
        for (int i = 0; i < 30000 && !done_c; i++) tick(1);
        n_checks++; if (done_c !== 1'b1) $display("FAIL full_timeout: Done=%b want 1", done_c); else n_pass++;
        n_checks++; if (ck_c !== 16'hE000) $display("FAIL full_csum: got %h want e000", ck_c); else n_pass++;
        tick(1);
        n_checks++; if (busy_c !== 1'b0 || done_c !== 1'b0) $display("FAIL full_end: busy/done got %b%b want 00", busy_c, done_c); else n_pass++;
        n_checks++; if (acc_c !== 8192 || dn_c !== 1) $display("FAIL full_counts: acc=%0d done=%0d want 8192/1", acc_c, dn_c); else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        acc_b = 0; dn_b = 0; pe_b = 0; bad = 0;
        mem_b[0] = 8'h11; mem_b[1] = 8'h22; mem_b[2] = 8'h33; mem_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) q_b.push_back('{addr: 13'(i), data: mem_b[i]});
        Out_Ready = 1'b0;
        go_b = 1'b1; tick(1); go_b = 1'b0;
        for (int i = 0; i < 20 && !ov_b; i++) tick(1);
        Out_Ready = 1'b1; tick(1); Out_Ready = 1'b0;
        for (int i = 0; i < 20 && !ov_b; i++) tick(1);
        for (int i = 0; i < 5; i++) begin
            if (ov_b !== 1'b1 || od_b !== 8'h22 || oa_b !== 13'd1) bad++;
            tick(1);
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles want 0", bad); else n_pass++;
        Out_Ready = 1'b1;
        for (int i = 0; i < 50 && !done_b; i++) tick(1);
        n_checks++; if (done_b !== 1'b1) $display("FAIL bp_timeout: Done=%b want 1", done_b); else n_pass++;
        n_checks++; if (ck_b !== 16'h00AA) $display("FAIL bp_csum: got %h want 00aa", ck_b); else n_pass++;
        tick(1);
        n_checks++; if (pe_b !== 4) $display("FAIL bp_reads: got %0d P_En cycles want 4", pe_b); else n_pass++;
        n_checks++; if (acc_b !== 4 || dn_b !== 1) $display("FAIL bp_counts: acc=%0d done=%0d want 4/1", acc_b, dn_b); else n_pass++;
    endtask

    task automatic test_go_busy();
        acc_a = 0; dn_a = 0; Out_Ready = 1'b1;
        push_a8();
        go_a = 1'b1; tick(1); go_a = 1'b0;
        for (int i = 0; i < 50 && acc_a < 2; i++) tick(1);
        go_a = 1'b1; tick(1); go_a = 1'b0;
        tick(2);
        go_a = 1'b1; tick(1); go_a = 1'b0;
        wait_done_a("gobusy");
        tick(4);
        n_checks++; if (acc_a !== 8 || dn_a !== 1 || q_a.size() !== 0)
            $display("FAIL gobusy_counts: acc=%0d done=%0d left=%0d want 8/1/0", acc_a, dn_a, q_a.size()); else n_pass++;
        n_checks++; if (busy_a !== 1'b0 || ck_a !== 16'h001C) $display("FAIL gobusy_end: busy=%b csum=%h want 0/001c", busy_a, ck_a); else n_pass++;
    endtask

    task automatic test_async_reset();
        acc_a = 0; dn_a = 0; Out_Ready = 1'b1;
        push_a8();
        go_a = 1'b1; tick(1); go_a = 1'b0;
        for (int i = 0; i < 50 && acc_a < 3; i++) tick(1);
        Out_Ready = 1'b0;
        for (int i = 0; i < 20 && !ov_a; i++) tick(1);
        n_checks++; if (ov_a !== 1'b1 || ck_a !== 16'd3) $display("FAIL arst_pre: valid=%b csum=%h want 1/0003", ov_a, ck_a); else n_pass++;
        #2 Rst = 1'b1;
        #1;
        n_checks++; if (ov_a !== 1'b0 || pen_a !== 1'b0 || busy_a !== 1'b0 || ck_a !== 16'd0)
            $display("FAIL arst_now: valid/pen/busy=%b%b%b csum=%h want 000/0000", ov_a, pen_a, busy_a, ck_a); else n_pass++;
        Rst = 1'b0;
        q_a.delete();
        tick(1);
        acc_a = 0; dn_a = 0; Out_Ready = 1'b1;
        push_a8();
        go_a = 1'b1; tick(1); go_a = 1'b0;
        for (int i = 0; i < 20 && !ov_a; i++) tick(1);
        n_checks++; if (ov_a !== 1'b1 || oa_a !== 13'd0) $display("FAIL arst_restart: valid=%b addr=%0d want 1/0", ov_a, oa_a); else n_pass++;
        wait_done_a("arst");
        tick(1);
        n_checks++; if (acc_a !== 8 || ck_a !== 16'h001C) $display("FAIL arst_counts: acc=%0d csum=%h want 8/001c", acc_a, ck_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        acc_a = 0; dn_a = 0; Out_Ready = 1'b1;
        push_a8(); push_a8();
        go_a = 1'b1;
        tick(1);
        wait_done_a("b2b_first");
        n_checks++; if (ck_a !== 16'h001C) $display("FAIL b2b_csum1: got %h want 001c", ck_a); else n_pass++;
        tick(1);
        n_checks++; if (busy_a !== 1'b0 || ck_a !== 16'h001C) $display("FAIL b2b_idle: busy=%b csum=%h want 0/001c", busy_a, ck_a); else n_pass++;
        tick(1);
        n_checks++; if (busy_a !== 1'b1 || ck_a !== 16'd0 || pen_a !== 1'b1)
            $display("FAIL b2b_restart: busy=%b pen=%b csum=%h want 1/1/0000", busy_a, pen_a, ck_a); else n_pass++;
        go_a = 1'b0;
        wait_done_a("b2b_second");
        tick(1);
        n_checks++; if (acc_a !== 16 || dn_a !== 2 || q_a.size() !== 0 || ck_a !== 16'h001C)
            $display("FAIL b2b_counts: acc=%0d done=%0d left=%0d csum=%h want 16/2/0/001c", acc_a, dn_a, q_a.size(), ck_a); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_a[i] = 8'(i);
        for (int i = 0; i < 4; i++) mem_b[i] = 8'h00;
        acc_a = 0; acc_b = 0; acc_c = 0; dn_a = 0; dn_b = 0; dn_c = 0; pe_b = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_go_busy();
        test_async_reset();
        test_back_to_back();
        test_full_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
